// File: rtl/hcp_frame_transmitter.sv
// HCP upstream framer: bit-stuffs payload bytes into one MSB-first stream and
// emits it on sbda as bytes, wrapped in start and stop frame bytes.
module hcp_frame_transmitter #(
    parameter logic [7:0] START_FRAME = 8'h7E,
    parameter logic [7:0] STOP_FRAME  = 8'hFE,
    parameter int         STUFF_LIMIT = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [7:0] sbda,
    output logic       sbda_valid,
    output logic       sending,
    output logic       busy
);

    // Handshake: a byte moves on a rising clk edge where tx_valid && tx_ready;
    // tx_ready depends only on state (and rst_n), never on tx_valid.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        SHIFT = 3'd2,
        FETCH = 3'd3,
        PAD   = 3'd4,
        STOP  = 3'd5
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STUFF_LIMIT);

    state_t     state;
    logic [7:0] in_sr;
    logic [3:0] in_cnt;
    logic       last_r;
    logic [3:0] ones_cnt;
    logic [7:0] out_sr;
    logic [3:0] out_cnt;
    logic       push_en;
    logic       push_bit;

    assign tx_ready = rst_n && (state == IDLE || state == FETCH);
    assign busy     = (state != IDLE);

    // One stuffed bit per cycle enters the output packer from SHIFT or PAD.
    always_comb begin
        push_en  = 1'b0;
        push_bit = 1'b0;
        if (state == SHIFT) begin
            if (ones_cnt == LIMIT) begin
                push_en = 1'b1;
            end else if (in_cnt != 4'd0) begin
                push_en  = 1'b1;
                push_bit = in_sr[7];
            end
        end else if (state == PAD) begin
            push_en = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_sr      <= 8'h00;
            in_cnt     <= 4'd0;
            last_r     <= 1'b0;
            ones_cnt   <= 4'd0;
            out_sr     <= 8'h00;
            out_cnt    <= 4'd0;
            sbda       <= 8'h00;
            sbda_valid <= 1'b0;
            sending    <= 1'b0;
        end else begin
            sbda_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        in_sr    <= tx_data;
                        in_cnt   <= 4'd8;
                        last_r   <= tx_last;
                        ones_cnt <= 4'd0;
                        out_sr   <= 8'h00;
                        out_cnt  <= 4'd0;
                        state    <= START;
                    end
                end
                START: begin
                    sbda       <= START_FRAME;
                    sbda_valid <= 1'b1;
                    sending    <= 1'b1;
                    state      <= SHIFT;
                end
                SHIFT: begin
                    if (ones_cnt == LIMIT) begin
                        ones_cnt <= 4'd0;
                    end else if (in_cnt != 4'd0) begin
                        in_sr    <= {in_sr[6:0], 1'b0};
                        in_cnt   <= in_cnt - 4'd1;
                        ones_cnt <= in_sr[7] ? ones_cnt + 4'd1 : 4'd0;
                    end else if (!last_r) begin
                        state <= FETCH;
                    end else if (out_cnt != 4'd0) begin
                        state <= PAD;
                    end else begin
                        state <= STOP;
                    end
                end
                FETCH: begin
                    // ones_cnt and out_cnt carry over so stuffing spans bytes
                    if (tx_valid) begin
                        in_sr  <= tx_data;
                        in_cnt <= 4'd8;
                        last_r <= tx_last;
                        state  <= SHIFT;
                    end
                end
                PAD: begin
                    if (out_cnt == 4'd7) state <= STOP;
                end
                STOP: begin
                    sbda       <= STOP_FRAME;
                    sbda_valid <= 1'b1;
                    sending    <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (push_en) begin
                out_sr <= {out_sr[6:0], push_bit};
                if (out_cnt == 4'd7) begin
                    sbda       <= {out_sr[6:0], push_bit};
                    sbda_valid <= 1'b1;
                    out_cnt    <= 4'd0;
                end else begin
                    out_cnt <= out_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hcp_frame_transmitter.sv
// Bench for hcp_frame_transmitter: directed frames with literal expectations,
// then random frames checked against a queue-based stuffing model.
module tb_hcp_frame_transmitter;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic [7:0] sbda;
  logic       sbda_valid;
  logic       sending;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int run1     = 0;

  logic [7:0] exp_q[$];
  int         acc_q[$];

  hcp_frame_transmitter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_last    (tx_last),
    .tx_ready   (tx_ready),
    .sbda       (sbda),
    .sbda_valid (sbda_valid),
    .sending    (sending),
    .busy       (busy)
  );

  // clock / reset-independent cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: serialize, insert a 0 after every run of five 1s, pad to a byte.
  task automatic model_frame(input logic [7:0] bytes[$]);
    logic bits[$];
    int run = 0;
    logic [7:0] b;
    foreach (bytes[k]) begin
      for (int i = 7; i >= 0; i--) begin
        bits.push_back(bytes[k][i]);
        run = bytes[k][i] ? run + 1 : 0;
        if (run == 5) begin
          bits.push_back(1'b0);
          run = 0;
        end
      end
    end
    while (bits.size() % 8 != 0) bits.push_back(1'b0);
    exp_q.push_back(8'h7E);
    for (int j = 0; j < bits.size(); j += 8) begin
      for (int i = 0; i < 8; i++) b[7-i] = bits[j+i];
      exp_q.push_back(b);
    end
    exp_q.push_back(8'hFE);
  endtask

  // Driver: called at a negedge, returns at a negedge with tx_valid low.
  task automatic xfer(input logic [7:0] d, input logic last, input logic first);
    int t = 0;
    tx_data  = d;
    tx_last  = last;
    tx_valid = 1'b1;
    while (!tx_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("xfer_timeout", 32'(t < 300), 32'd1);
    @(posedge clk);
    #1;
    if (first) acc_q.push_back(cyc);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input int gap_max);
    foreach (bytes[k]) begin
      xfer(bytes[k], 1'(k == bytes.size() - 1), 1'(k == 0));
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 600) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_sending"}, sending, 1'b0);
    check({tag, "_ready"}, tx_ready, 1'b1);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_sbda"}, sbda, 8'h00);
    check({tag, "_valid"}, sbda_valid, 1'b0);
    check({tag, "_sending"}, sending, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_ready"}, tx_ready, 1'b0);
  endtask

  // Scoreboard: every sbda strobe must match the head of exp_q.
  always @(negedge clk) begin
    if (rst_n && sbda_valid) begin
      if (exp_q.size() == 0) begin
        check("extra_byte", 32'(sbda), 32'h100);
      end else begin
        check("sbda_byte", sbda, exp_q.pop_front());
        if (sbda == 8'h7E) begin
          run1 = 0;
          check("start_sending", sending, 1'b1);
          check("start_ready_low", tx_ready, 1'b0);
          if (acc_q.size() != 0) check("start_latency", cyc - acc_q.pop_front(), 1);
        end else if (sbda != 8'hFE) begin
          check("payload_sending", sending, 1'b1);
          for (int i = 7; i >= 0; i--) begin
            run1 = sbda[i] ? run1 + 1 : 0;
            check("six_ones", 32'(run1 >= 6), 32'd0);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] fr[$];
    int t;
    rst_n    = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks("por");
    rst_n = 1'b1;
    @(negedge clk);

    // single 0x00 byte
    exp_q = '{8'h7E, 8'h00, 8'hFE};
    xfer(8'h00, 1'b1, 1'b1);
    wait_idle("zero");

    // 0xFF needs a stuff bit and a padded tail
    exp_q = '{8'h7E, 8'hFB, 8'h80, 8'hFE};
    xfer(8'hFF, 1'b1, 1'b1);
    wait_idle("ff");

    // 0x7E payload is stuffed so it never looks like a start frame
    exp_q = '{8'h7E, 8'h7D, 8'h00, 8'hFE};
    xfer(8'h7E, 1'b1, 1'b1);
    wait_idle("flag");

    // two bytes with an input gap; the ones run continues across the gap
    exp_q = '{8'h7E, 8'h0F, 8'hB8, 8'h00, 8'hFE};
    xfer(8'h0F, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check("gap_ready_shift", tx_ready, 1'b0);
    t = 0;
    while (!tx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("fetch_ready", tx_ready, 1'b1);
    check("fetch_busy", busy, 1'b1);
    check("fetch_sending", sending, 1'b1);
    repeat (3) @(negedge clk);
    check("fetch_hold", sbda_valid, 1'b0);
    xfer(8'hF0, 1'b1, 1'b0);
    wait_idle("two");

    // reset in the middle of shifting a 0xFF frame
    exp_q = '{8'h7E, 8'hFB, 8'h80, 8'hFE};
    xfer(8'hFF, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("pre_rst_sending", sending, 1'b1);
    rst_n = 1'b0;
    #1;
    reset_checks("mid_rst");
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q = '{8'h7E, 8'h00, 8'hFE};
    xfer(8'h00, 1'b1, 1'b1);
    wait_idle("after_rst");

    // back-to-back frames, second offered immediately
    exp_q = '{8'h7E, 8'h00, 8'hFE, 8'h7E, 8'h01, 8'hFE};
    xfer(8'h00, 1'b1, 1'b1);
    xfer(8'h01, 1'b1, 1'b1);
    wait_idle("b2b");

    // random frames against the model
    for (int f = 0; f < 40; f++) begin
      fr.delete();
      for (int k = 0; k < $urandom_range(1, 4); k++)
        fr.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom_range(0, 255)));
      model_frame(fr);
      send_frame(fr, ($urandom_range(0, 1) == 0) ? 0 : 12);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle("rand");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
